regfile_wb_arbiter: RTL and testbench



---
 rtl/regfile_pkg.sv | 19 +
 rtl/regfile_wb_arbiter_slot.sv | 39 +++
 rtl/regfile_wb_arbiter.sv | 99 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-bank write-back arbiter.
package regfile_pkg;

  localparam int WORD_SIZE = 32;
  localparam int REG_SIZE  = 5;
  localparam int REG_TOTAL = 32;

  typedef logic port_idx_t;

  typedef struct packed {
    logic [REG_SIZE-1:0]  dest;
    logic [WORD_SIZE-1:0] data;
  } wb_req_t;

  function automatic logic [REG_TOTAL-1:0] reg_decode(input logic [REG_SIZE-1:0] r);
    return {{(REG_TOTAL-1){1'b0}}, 1'b1} << r;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_slot.sv
// One-entry write-back holding slot with same-cycle drain/refill and an age flag
// that marks the entry as younger than the one held in the sibling slot.
module wb_slot
  import regfile_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    load,
  input  logic    grant,
  input  logic    other_busy,
  input  logic    other_grant,
  input  wb_req_t req,
  output logic    ready,
  output logic    occupied,
  output logic    age,
  output wb_req_t held
);

  assign ready = !occupied || grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occupied <= 1'b0;
      age      <= 1'b0;
      held     <= '0;
    end else if (load) begin
      occupied <= 1'b1;
      held     <= req;
      // Younger only if the sibling keeps its entry across this edge.
      age      <= other_busy;
    end else if (grant) begin
      occupied <= 1'b0;
      age      <= 1'b0;
    end else if (other_grant) begin
      age      <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-port write-back arbiter feeding the register bank's single write port.
// Define X0_WRITE_DROP_EN to silently discard writes to register 0.
module regfile_wb_arbiter
  import regfile_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [REG_SIZE-1:0]  req0_reg,
  input  logic [WORD_SIZE-1:0] req0_data,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [REG_SIZE-1:0]  req1_reg,
  input  logic [WORD_SIZE-1:0] req1_data,
  output logic                 RegWrite,
  output logic [REG_SIZE-1:0]  WriteReg,
  output logic [WORD_SIZE-1:0] WriteData,
  output logic [REG_TOTAL-1:0] pending_mask
);

  logic [1:0] valid, ready, load, drop, grant, occ, age;
  wb_req_t    req  [2];
  wb_req_t    held [2];
  port_idx_t  winner;
  logic       rr_ptr;

  assign valid      = {req1_valid, req0_valid};
  assign req[0]     = {req0_reg, req0_data};
  assign req[1]     = {req1_reg, req1_data};
  assign req0_ready = ready[0];
  assign req1_ready = ready[1];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
      localparam int OI = 1 - gi;
`ifdef X0_WRITE_DROP_EN
      assign drop[gi] = (req[gi].dest == '0);
`else
      assign drop[gi] = 1'b0;
`endif
      assign load[gi] = valid[gi] && ready[gi] && !drop[gi];

      wb_slot u_slot (
        .clk         (clk),
        .rst         (rst),
        .load        (load[gi]),
        .grant       (grant[gi]),
        .other_busy  (occ[OI] && !grant[OI]),
        .other_grant (grant[OI]),
        .req         (req[gi]),
        .ready       (ready[gi]),
        .occupied    (occ[gi]),
        .age         (age[gi]),
        .held        (held[gi])
      );
    end
  endgenerate

  // Same destination with differing ages: the younger slot must wait so the
  // bank sees the writes in program order; otherwise round-robin decides.
  always_comb begin
    winner = rr_ptr;
    if (occ == 2'b01) begin
      winner = 1'b0;
    end else if (occ == 2'b10) begin
      winner = 1'b1;
    end else if (held[0].dest == held[1].dest && age[0] != age[1]) begin
      winner = age[0];
    end
    grant[0] = |occ && !winner;
    grant[1] = |occ && winner;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWrite  <= 1'b0;
      WriteReg  <= '0;
      WriteData <= '0;
      rr_ptr    <= 1'b0;
    end else begin
      RegWrite <= |occ;
      if (|occ) begin
        WriteReg  <= held[winner].dest;
        WriteData <= held[winner].data;
        rr_ptr    <= !winner;
      end
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < 2; i++) begin
      if (occ[i]) pending_mask |= reg_decode(held[i].dest);
    end
    if (RegWrite) pending_mask |= reg_decode(WriteReg);
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with an in-order write-back scoreboard.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 req0_valid, req1_valid;
  logic                 req0_ready, req1_ready;
  logic [REG_SIZE-1:0]  req0_reg, req1_reg;
  logic [WORD_SIZE-1:0] req0_data, req1_data;
  logic                 RegWrite;
  logic [REG_SIZE-1:0]  WriteReg;
  logic [WORD_SIZE-1:0] WriteData;
  logic [REG_TOTAL-1:0] pending_mask;

  typedef struct {
    logic [REG_SIZE-1:0]  r;
    logic [WORD_SIZE-1:0] d;
  } exp_t;

  exp_t                 sb [$];
  exp_t                 mon_e;
  logic [WORD_SIZE-1:0] bank [REG_TOTAL];
  int                   total = 0;
  int                   bad   = 0;
  int                   i0, i1;

  regfile_wb_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_reg     (req0_reg),
    .req0_data    (req0_data),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_reg     (req1_reg),
    .req1_data    (req1_data),
    .RegWrite     (RegWrite),
    .WriteReg     (WriteReg),
    .WriteData    (WriteData),
    .pending_mask (pending_mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Bank-side monitor: every RegWrite must match the oldest scoreboard entry.
  always @(negedge clk) begin
    if (!rst && RegWrite) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", 64'(RegWrite), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        $display("wb write reg=%0d data=%08h (expected reg=%0d data=%08h)",
                 WriteReg, WriteData, mon_e.r, mon_e.d);
        chk("wb_reg", 64'(WriteReg), 64'(mon_e.r));
        chk("wb_data", 64'(WriteData), 64'(mon_e.d));
        bank[WriteReg] = WriteData;
      end
    end
  end

  initial begin
    for (int r = 0; r < REG_TOTAL; r++) bank[r] = '0;
    rst = 1'b1;
    req0_valid = 1'b0; req0_reg = '0; req0_data = '0;
    req1_valid = 1'b0; req1_reg = '0; req1_data = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_regwrite", 64'(RegWrite), 64'd0);
    chk("rst_writereg", 64'(WriteReg), 64'd0);
    chk("rst_writedata", 64'(WriteData), 64'd0);
    chk("rst_pending", 64'(pending_mask), 64'd0);
    chk("rst_ready0", 64'(req0_ready), 64'd1);
    chk("rst_ready1", 64'(req1_ready), 64'd1);
    rst = 1'b0;

    // Single write, latency and pending window
    req0_valid = 1'b1; req0_reg = 5'd5; req0_data = 32'hDEADBEEF;
    chk("t1_ready0", 64'(req0_ready), 64'd1);
    sb.push_back('{5'd5, 32'hDEADBEEF});
    @(negedge clk);
    req0_valid = 1'b0;
    chk("t1_regwrite_e", 64'(RegWrite), 64'd0);
    chk("t1_pend_slot", 64'(pending_mask), 64'h20);
    @(negedge clk);
    chk("t1_regwrite_e1", 64'(RegWrite), 64'd1);
    chk("t1_pend_out", 64'(pending_mask), 64'h20);
    @(negedge clk);
    chk("t1_regwrite_e2", 64'(RegWrite), 64'd0);
    chk("t1_pend_clear", 64'(pending_mask), 64'd0);

    // Both ports streaming to different registers
    do_reset();
    i0 = 0; i1 = 0;
    for (int c = 0; c < 8; c++) begin
      req0_valid = 1'b1; req0_reg = 5'd3; req0_data = 32'(32'h300 + i0);
      req1_valid = 1'b1; req1_reg = 5'd7; req1_data = 32'(32'h700 + i1);
      chk("t2_ready0", 64'(req0_ready), 64'((c == 0) || (c % 2 == 1)));
      chk("t2_ready1", 64'(req1_ready), 64'(c % 2 == 0));
      if (req0_ready) begin
        sb.push_back('{5'd3, 32'(32'h300 + i0)});
        i0++;
      end
      if (req1_ready) begin
        sb.push_back('{5'd7, 32'(32'h700 + i1)});
        i1++;
      end
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("t2_drained", 64'(sb.size()), 64'd0);

    // Same destination from both ports keeps program order
    do_reset();
    req0_valid = 1'b1; req0_reg = 5'd4; req0_data = 32'h44;
    req1_valid = 1'b1; req1_reg = 5'd9; req1_data = 32'h1;
    chk("t3_ready0_a", 64'(req0_ready), 64'd1);
    chk("t3_ready1_a", 64'(req1_ready), 64'd1);
    sb.push_back('{5'd4, 32'h44});
    sb.push_back('{5'd9, 32'h1});
    @(negedge clk);
    req1_valid = 1'b0;
    req0_reg = 5'd9; req0_data = 32'h2;
    chk("t3_ready0_b", 64'(req0_ready), 64'd1);
    chk("t3_ready1_b", 64'(req1_ready), 64'd0);
    sb.push_back('{5'd9, 32'h2});
    @(negedge clk);
    req0_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("t3_bank9", 64'(bank[9]), 64'h2);
    chk("t3_drained", 64'(sb.size()), 64'd0);

    // Reset with both slots full discards held writes
    do_reset();
    req0_valid = 1'b1; req0_reg = 5'd10; req0_data = 32'hA0A0;
    req1_valid = 1'b1; req1_reg = 5'd11; req1_data = 32'hB1B1;
    sb.push_back('{5'd10, 32'hA0A0});
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("t4_pend_full", 64'(pending_mask), 64'h0C00);
    @(negedge clk);
    chk("t4_regwrite", 64'(RegWrite), 64'd1);
    chk("t4_pend_mixed", 64'(pending_mask), 64'h0C00);
    #2 rst = 1'b1;
    #1;
    chk("t4_rst_regwrite", 64'(RegWrite), 64'd0);
    chk("t4_rst_writereg", 64'(WriteReg), 64'd0);
    chk("t4_rst_writedata", 64'(WriteData), 64'd0);
    chk("t4_rst_pending", 64'(pending_mask), 64'd0);
    chk("t4_rst_ready0", 64'(req0_ready), 64'd1);
    chk("t4_rst_ready1", 64'(req1_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("t4_no_stale", 64'(sb.size()), 64'd0);

    // Port 0 alone: same-cycle drain and refill
    for (int c = 0; c < 7; c++) begin
      chk("t5_regwrite", 64'(RegWrite), 64'((c >= 2) && (c <= 5)));
      if (c < 4) begin
        req0_valid = 1'b1; req0_reg = 5'(12 + c); req0_data = 32'(32'h5000 + c);
        chk("t5_ready0", 64'(req0_ready), 64'd1);
        sb.push_back('{5'(12 + c), 32'(32'h5000 + c)});
      end else begin
        req0_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk("t5_drained", 64'(sb.size()), 64'd0);

    // Write to register 0
    req0_valid = 1'b1; req0_reg = 5'd0; req0_data = 32'hFF;
    chk("t6_ready0", 64'(req0_ready), 64'd1);
`ifndef X0_WRITE_DROP_EN
    sb.push_back('{5'd0, 32'hFF});
`endif
    @(negedge clk);
    req0_valid = 1'b0;
`ifdef X0_WRITE_DROP_EN
    chk("t6_pend", 64'(pending_mask), 64'd0);
    @(negedge clk);
    chk("t6_regwrite", 64'(RegWrite), 64'd0);
`else
    chk("t6_pend", 64'(pending_mask), 64'd1);
    @(negedge clk);
    chk("t6_regwrite", 64'(RegWrite), 64'd1);
`endif
    @(negedge clk);
    chk("t6_drained", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
